// File: rtl/signed_adder_lanes_if.sv
// Beat-level bus of the lane adder: input handshake with operands, output handshake with results.
interface signed_adder_lanes_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned IN1_WIDTH = 20,
    parameter int unsigned IN2_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 32
);
    logic                           in_valid;
    logic                           in_ready;
    logic                           sub;
    logic [NUM_LANES*IN1_WIDTH-1:0] a;
    logic [NUM_LANES*IN2_WIDTH-1:0] b;
    logic                           out_valid;
    logic                           out_ready;
    logic [NUM_LANES*OUT_WIDTH-1:0] out;
    logic [NUM_LANES-1:0]           ovf;

    modport slave (
        input  in_valid, sub, a, b, out_ready,
        output in_ready, out_valid, out, ovf
    );

    modport master (
        output in_valid, sub, a, b, out_ready,
        input  in_ready, out_valid, out, ovf
    );
endinterface

// File: rtl/signed_adder_lanes.sv
// Multi-lane pipelined signed add/sub with per-lane saturate-or-wrap narrowing,
// valid/ready pipeline that stalls as a whole, and a sticky per-lane overflow status.
module signed_adder_lanes #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned IN1_WIDTH   = 20,
    parameter int unsigned IN2_WIDTH   = 32,
    parameter int unsigned OUT_WIDTH   = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter string       SATURATE    = "TRUE"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ovf_clear,
    output logic [NUM_LANES-1:0] ovf_sticky,
    signed_adder_lanes_if.slave  io
);

    localparam int unsigned SUM_W  = ((IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH) + 1;
    localparam int unsigned DATA_W = NUM_LANES * OUT_WIDTH;
    localparam int unsigned LAST   = PIPE_STAGES - 1;
    localparam bit          SAT_EN = (SATURATE == "TRUE");

    localparam logic [OUT_WIDTH-1:0] MIN_NEG = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] MAX_POS = ~MIN_NEG;

    logic [OUT_WIDTH-1:0] lane_res [NUM_LANES];
    logic                 lane_ovf [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic signed [SUM_W-1:0] a_ext;
        logic signed [SUM_W-1:0] b_ext;
        logic signed [SUM_W-1:0] sum;

        // Full-precision arithmetic; SUM_W leaves one guard bit so this never wraps.
        always_comb begin
            a_ext = SUM_W'($signed(io.a[i*IN1_WIDTH +: IN1_WIDTH]));
            b_ext = SUM_W'($signed(io.b[i*IN2_WIDTH +: IN2_WIDTH]));
            sum   = io.sub ? (b_ext - a_ext) : (b_ext + a_ext);
        end

        if (OUT_WIDTH >= SUM_W) begin : g_wide
            assign lane_res[i] = OUT_WIDTH'(sum);
            assign lane_ovf[i] = 1'b0;
        end else begin : g_narrow
            // In range iff every bit from the sign down to the output MSB agrees.
            logic [SUM_W-OUT_WIDTH:0] hi;
            assign hi          = sum[SUM_W-1:OUT_WIDTH-1];
            assign lane_ovf[i] = !((&hi) || !(|hi));

            if (SAT_EN) begin : g_sat
                assign lane_res[i] = !lane_ovf[i] ? sum[OUT_WIDTH-1:0]
                                   : (sum[SUM_W-1] ? MIN_NEG : MAX_POS);
            end else begin : g_wrap
                assign lane_res[i] = sum[OUT_WIDTH-1:0];
            end
        end
    end

    logic [DATA_W-1:0]    stage_in_data;
    logic [NUM_LANES-1:0] stage_in_ovf;

    always_comb begin
        stage_in_data = '0;
        stage_in_ovf  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            stage_in_data[i*OUT_WIDTH +: OUT_WIDTH] = lane_res[i];
            stage_in_ovf[i]                         = lane_ovf[i];
        end
    end

    logic [PIPE_STAGES-1:0] valid_q;
    logic [DATA_W-1:0]      data_q [PIPE_STAGES];
    logic [NUM_LANES-1:0]   ovf_q  [PIPE_STAGES];
    logic [NUM_LANES-1:0]   ovf_sticky_q;
    logic [NUM_LANES-1:0]   ovf_sticky_d;
    logic                   advance;
    logic                   accept;
    logic                   consume;

    // Whole pipe moves together; an empty or draining output slot lets it advance.
    assign advance     = !valid_q[LAST] || io.out_ready;
    assign io.in_ready = advance && !reset;
    assign accept      = io.in_valid && io.in_ready;
    assign consume     = valid_q[LAST] && io.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                ovf_q[k]  <= '0;
            end
        end else if (advance) begin
            valid_q[0] <= accept;
            data_q[0]  <= accept ? stage_in_data : '0;
            ovf_q[0]   <= accept ? stage_in_ovf : '0;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                data_q[k]  <= data_q[k-1];
                ovf_q[k]   <= ovf_q[k-1];
            end
        end
    end

    // Clear first, then OR in the consumed beat so a coincident overflow survives.
    always_comb begin
        ovf_sticky_d = ovf_clear ? '0 : ovf_sticky_q;
        if (consume) begin
            ovf_sticky_d = ovf_sticky_d | ovf_q[LAST];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky_q <= '0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign io.out_valid = valid_q[LAST];
    assign io.out       = data_q[LAST];
    assign io.ovf       = ovf_q[LAST];
    assign ovf_sticky   = ovf_sticky_q;

endmodule
